// File: rtl/adc_chan_sequencer.sv
// Round-robin ADC mux scheduler: per enabled channel, write the mux config, run
// conversions, drop settling samples and forward the first valid one, guarded by a watchdog.
//
// state  | meaning
// IDLE   | no requests, waiting for enable && sync
// SELECT | pick next enabled channel at or above ch_idx, latch command
// WREG   | config write requested, waiting for wreg_done
// CONV   | conversion requested, discarding settling results
// NEXT   | sample delivered, choose the following channel
module adc_chan_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DISCARD = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              enable,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [13:0]       cfg_word,
  output logic              wreg_req,
  output logic [15:0]       wreg_cmd,
  input  logic              wreg_done,
  output logic              conv_req,
  input  logic              conv_done,
  input  logic [23:0]       conv_data,
  output logic              smp_valid,
  output logic [23:0]       smp_data,
  output logic [1:0]        smp_ch,
  output logic              scan_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_WREG   = 3'd2;
  localparam logic [2:0] S_CONV   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  localparam logic [3:0]  DISC_LD = 4'(DISCARD);
  localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);

  logic [2:0]  r_state;
  logic [1:0]  r_ch_idx;
  logic [1:0]  r_ch;
  logic        r_sync_pend;
  logic [3:0]  r_disc_cnt;
  logic [15:0] r_wait;
  logic [15:0] r_wreg_cmd;
  logic        r_smp_valid;
  logic [23:0] r_smp_data;
  logic [1:0]  r_smp_ch;
  logic        r_err_timeout;

  logic [2:0]  w_sel;
  logic [2:0]  w_nxt;
  logic        w_top;
  logic [15:0] w_wait_inc;
  logic        w_to_hit;
  logic        w_sync_now;

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  function automatic logic [2:0] find_from(input logic [NUM_CH-1:0] mask, input logic [2:0] start);
    logic [2:0]        res;
    logic [1:0]        idx;
    logic [NUM_CH-1:0] tmp;
    res = 3'b000;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = 2'((int'(start) + i) % NUM_CH);
      tmp = mask >> idx;
      if (tmp[0]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic is_top(input logic [NUM_CH-1:0] mask, input logic [1:0] ch);
    logic [NUM_CH-1:0] tmp;
    tmp = mask >> ch;
    return (tmp >> 1) == '0;
  endfunction

  always_comb begin
    w_sel = find_from(ch_mask, {1'b0, r_ch_idx});
    w_nxt = find_from(ch_mask, {1'b0, r_ch} + 3'd1);
    w_top = is_top(ch_mask, r_ch);
  end

  assign w_wait_inc = r_wait + 16'd1;
  assign w_to_hit   = (w_wait_inc == TO_CNT);
  assign w_sync_now = r_sync_pend | sync;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state       <= S_IDLE;
      r_ch_idx      <= 2'd0;
      r_ch          <= 2'd0;
      r_sync_pend   <= 1'b0;
      r_disc_cnt    <= 4'd0;
      r_wait        <= 16'd0;
      r_wreg_cmd    <= 16'd0;
      r_smp_valid   <= 1'b0;
      r_smp_data    <= 24'd0;
      r_smp_ch      <= 2'd0;
      r_err_timeout <= 1'b0;
    end else begin
      r_smp_valid <= 1'b0;
      if (sync && r_state != S_IDLE) r_sync_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_sync_pend <= 1'b0;
          r_wait      <= 16'd0;
          if (enable && sync) begin
            r_err_timeout <= 1'b0;
            r_ch_idx      <= 2'd0;
            r_state       <= S_SELECT;
          end
        end
        S_SELECT: begin
          r_wait <= 16'd0;
          if (!w_sel[2]) begin
            r_state <= S_IDLE;
          end else begin
            r_ch       <= w_sel[1:0];
            r_wreg_cmd <= {w_sel[1:0], cfg_word};
            r_disc_cnt <= DISC_LD;
            r_state    <= S_WREG;
          end
        end
        S_WREG: begin
          if (wreg_done) begin
            r_wait <= 16'd0;
            if (r_sync_pend) begin
              r_sync_pend <= 1'b0;
              r_ch_idx    <= 2'd0;
              r_state     <= S_SELECT;
            end else begin
              r_state <= S_CONV;
            end
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_CONV: begin
          if (conv_done) begin
            r_wait <= 16'd0;
            if (r_sync_pend) begin
              // restart drops this result even if it was the valid one
              r_sync_pend <= 1'b0;
              r_ch_idx    <= 2'd0;
              r_state     <= S_SELECT;
            end else if (r_disc_cnt != 4'd0) begin
              r_disc_cnt <= r_disc_cnt - 4'd1;
            end else begin
              r_smp_data  <= conv_data;
              r_smp_ch    <= r_ch;
              r_smp_valid <= 1'b1;
              r_state     <= S_NEXT;
            end
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_NEXT: begin
          r_wait <= 16'd0;
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_sync_now) begin
            r_sync_pend <= 1'b0;
            r_ch_idx    <= 2'd0;
            r_state     <= S_SELECT;
          end else if (w_nxt[2] && w_nxt[1:0] == r_ch) begin
            // single enabled channel: mux already set, skip the write and settling
            r_disc_cnt <= 4'd0;
            r_state    <= S_CONV;
          end else begin
            if (w_nxt[2]) r_ch_idx <= w_nxt[1:0];
            r_state <= S_SELECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wreg_req    = (r_state == S_WREG);
  assign conv_req    = (r_state == S_CONV);
  assign busy        = (r_state != S_IDLE);
  assign scan_done   = (r_state == S_NEXT) && w_top;
  assign wreg_cmd    = r_wreg_cmd;
  assign smp_valid   = r_smp_valid;
  assign smp_data    = r_smp_data;
  assign smp_ch      = r_smp_ch;
  assign err_timeout = r_err_timeout;

endmodule
